// File: rtl/video_fetch_pkg.sv
// Shared timing constants, fetch FSM encoding and SRAM plane-address packing
// for the video fetch stage.
package video_defs;

  localparam logic [8:0] H_TOTAL     = 9'd384;
  localparam logic [8:0] H_ACT_START = 9'd64;
  localparam logic [8:0] H_ACTIVE    = 9'd256;
  localparam logic [8:0] H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam logic       PLANE_BASE  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_F0,
    ST_F1,
    ST_F2,
    ST_F3,
    ST_HOLD
  } fetch_st_t;

  function automatic logic [15:0] plane_addr(
    input logic [1:0] plane,
    input logic [4:0] col,
    input logic [7:0] row
  );
    return {PLANE_BASE, plane, col, row};
  endfunction

endpackage

// File: rtl/video_fetch_if.sv
// SRAM read port shared between the video fetch stage and the SRAM arbiter.
interface video_fetch_if;

  logic        video_slice;
  logic        pipe_ab;
  logic [7:0]  SRAM_DQ;
  logic [15:0] SRAM_ADDR;

  modport master (
    input  video_slice,
    input  pipe_ab,
    input  SRAM_DQ,
    output SRAM_ADDR
  );

  modport slave (
    output video_slice,
    output pipe_ab,
    output SRAM_DQ,
    input  SRAM_ADDR
  );

endinterface

// File: rtl/video_fetch_plane_shifter.sv
// Four 8-bit plane shift registers; emits one colour index per pixel tick,
// one tick behind the load/shift that produced it.
module plane_shifter (
  input  logic            clk24,
  input  logic            reset,
  input  logic            ce,
  input  logic            load,
  input  logic            shift,
  input  logic            active,
  input  logic [3:0][7:0] din,
  output logic [3:0]      coloridx
);

  logic [3:0][7:0] sr;

  always_ff @(posedge clk24) begin
    if (reset) begin
      sr       <= '0;
      coloridx <= '0;
    end else if (ce) begin
      coloridx <= active
        ? {sr[3][7], sr[2][7], sr[1][7], sr[0][7]}
        : 4'd0;
      if (load) begin
        sr <= din;
      end else if (shift) begin
        for (int i = 0; i < 4; i++) begin
          sr[i] <= {sr[i][6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/video_fetch.sv
// Per-line bit-plane fetch: reads four planes per column from SRAM during
// video slices and double-buffers them into the plane shifter.
module video_fetch
  import video_defs::*;
(
  input  logic         clk24,
  input  logic         reset,
  input  logic         ce_pixel,
  input  logic         line_start,
  input  logic [7:0]   row,
  video_fetch_if.master bus,
  output logic [3:0]   coloridx,
  output logic         borderx,
  output logic         underrun
);

  fetch_st_t       state;
  fetch_st_t       state_nx;
  logic [8:0]      hcnt;
  logic [4:0]      col;
  logic [3:0][7:0] fetch_reg;
  logic            fetch_valid;
  logic [1:0]      plane;
  logic            in_fetch;
  logic            tick;
  logic            active;
  logic [2:0]      rel;
  logic            boundary;
  logic            ld;
  logic            sample;

  assign tick   = ce_pixel & ~line_start;
  assign active = (hcnt >= H_ACT_START) && (hcnt < H_ACT_END);
  assign rel    = hcnt[2:0] - H_ACT_START[2:0];

  // Last active pixel has no following column to load.
  assign boundary =
    (hcnt == H_ACT_START - 9'd1) ||
    (active && rel == 3'd7 &&
     hcnt != H_ACT_END - 9'd1);

  assign ld     = tick & boundary & (state != ST_IDLE);
  assign sample = in_fetch & bus.video_slice & bus.pipe_ab;

  always_comb begin
    plane    = 2'd0;
    in_fetch = 1'b1;
    unique case (state)
      ST_F0:   plane = 2'd0;
      ST_F1:   plane = 2'd1;
      ST_F2:   plane = 2'd2;
      ST_F3:   plane = 2'd3;
      default: in_fetch = 1'b0;
    endcase
  end

  assign bus.SRAM_ADDR = in_fetch
    ? plane_addr(plane, col, row)
    : {PLANE_BASE, 15'd0};

  always_comb begin
    state_nx = state;
    if (line_start) begin
      state_nx = ST_F0;
    end else if (ld) begin
      state_nx = (col != 5'd31) ? ST_F0 : ST_IDLE;
    end else if (sample) begin
      unique case (state)
        ST_F0:   state_nx = ST_F1;
        ST_F1:   state_nx = ST_F2;
        ST_F2:   state_nx = ST_F3;
        ST_F3:   state_nx = ST_HOLD;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk24) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk24) begin
    if (reset) begin
      hcnt        <= '0;
      col         <= '0;
      fetch_reg   <= '0;
      fetch_valid <= 1'b0;
      underrun    <= 1'b0;
      borderx     <= 1'b1;
    end else if (line_start) begin
      hcnt        <= '0;
      col         <= '0;
      fetch_valid <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (tick) begin
        hcnt    <= (hcnt == H_TOTAL - 9'd1)
                   ? 9'd0 : hcnt + 9'd1;
        borderx <= ~active;
      end
      if (ld) begin
        fetch_valid <= 1'b0;
        col         <= col + 5'd1;
        if (!fetch_valid) underrun <= 1'b1;
      end else if (sample) begin
        fetch_reg[plane] <= bus.SRAM_DQ;
        if (state == ST_F3) fetch_valid <= 1'b1;
      end
    end
  end

  plane_shifter u_shift (
    .clk24    (clk24),
    .reset    (reset),
    .ce       (tick),
    .load     (ld),
    .shift    (active & ~ld),
    .active   (active),
    .din      (fetch_valid ? fetch_reg : '0),
    .coloridx (coloridx)
  );

endmodule

// File: tb/tb_video_fetch.sv
// Directed bench for video_fetch: SRAM plane model plus hand-computed
// expectations for addresses, pixels, border and underrun.
module tb_video_fetch;
  import video_defs::*;

  logic       clk24;
  logic       reset;
  logic       ce_pixel;
  logic       line_start;
  logic [7:0] row;
  logic [3:0] coloridx;
  logic       borderx;
  logic       underrun;

  video_fetch_if bus ();

  video_fetch dut (
    .clk24      (clk24),
    .reset      (reset),
    .ce_pixel   (ce_pixel),
    .line_start (line_start),
    .row        (row),
    .bus        (bus.master),
    .coloridx   (coloridx),
    .borderx    (borderx),
    .underrun   (underrun)
  );

  initial clk24 = 1'b0;
  always #5 clk24 = ~clk24;

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;
  int mode = 0;
  int pat  = 0;

  function automatic logic [7:0] mem(input logic [15:0] a);
    logic [1:0] pl;
    logic [4:0] c;
    pl = a[14:13];
    c  = a[12:8];
    case (pat)
      0: return (c == 5'd0 && (pl == 2'd0 || pl == 2'd3))
                ? 8'h80 : 8'h00;
      1: return {3'd0, c};
      default: return 8'hFF;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit ls, input bit ce);
    line_start      = ls;
    ce_pixel        = ce;
    bus.video_slice = 1'b1;
    case (mode)
      0:       bus.pipe_ab = 1'b1;
      1:       bus.pipe_ab = (cyc % 32) < 3;
      default: bus.pipe_ab = 1'b0;
    endcase
    bus.SRAM_DQ = mem(bus.SRAM_ADDR);
    @(posedge clk24);
    #1;
    cyc++;
    line_start = 1'b0;
    ce_pixel   = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step(0, 0);
      step(0, 0);
      step(0, 0);
      step(0, 1);
    end
  endtask

  initial begin
    logic [7:0] c;
    int         j;
    reset           = 1'b1;
    line_start      = 1'b0;
    ce_pixel        = 1'b0;
    row             = 8'h00;
    bus.video_slice = 1'b0;
    bus.pipe_ab     = 1'b0;
    bus.SRAM_DQ     = 8'h00;
    step(0, 0);
    step(0, 0);
    chk("rst_addr", bus.SRAM_ADDR, 16'h8000);
    chk("rst_cidx", coloridx, 4'd0);
    chk("rst_bdr", borderx, 1'b1);
    chk("rst_unr", underrun, 1'b0);
    chk("rst_hcnt", dut.hcnt, 9'd0);
    chk("rst_st", dut.state, ST_IDLE);
    reset = 1'b0;

    // column 0 plane fetch order and first active pixel
    row = 8'h10;
    pat = 0;
    step(1, 0);
    chk("t1_a0", bus.SRAM_ADDR, 16'h8010);
    step(0, 0);
    chk("t1_a1", bus.SRAM_ADDR, 16'hA010);
    step(0, 0);
    chk("t1_a2", bus.SRAM_ADDR, 16'hC010);
    step(0, 0);
    chk("t1_a3", bus.SRAM_ADDR, 16'hE010);
    step(0, 1);
    chk("t1_valid", dut.fetch_valid, 1'b1);
    run(62);
    chk("t1_bdr62", borderx, 1'b1);
    run(1);
    chk("t1_col1", bus.SRAM_ADDR, 16'h8110);
    chk("t1_bdr63", borderx, 1'b1);
    run(1);
    chk("t1_bdr64", borderx, 1'b0);
    chk("t1_pix0", coloridx, 4'b1001);
    chk("t1_unr", underrun, 1'b0);
    for (int k = 1; k < 8; k++) begin
      run(1);
      chk("t1_pixk", coloridx, 4'd0);
    end
    chk("t1_unr2", underrun, 1'b0);

    // full line, byte value = column number on every plane
    pat = 1;
    row = 8'h20;
    step(1, 0);
    run(64);
    for (int p = 0; p < 256; p++) begin
      run(1);
      c = 8'(p / 8);
      j = p % 8;
      chk("t2_pix", coloridx, {4{c[7 - j]}});
    end
    chk("t2_idle", dut.state, ST_IDLE);
    chk("t2_addr", bus.SRAM_ADDR, 16'h8000);
    chk("t2_bdr319", borderx, 1'b0);
    run(1);
    chk("t2_bdr320", borderx, 1'b1);
    chk("t2_cidx", coloridx, 4'd0);
    chk("t2_unr", underrun, 1'b0);

    // three slices per 32 clocks
    pat  = 2;
    mode = 1;
    step(1, 0);
    run(64);
    chk("t3_unr63", underrun, 1'b0);
    run(1);
    chk("t3_pix0", coloridx, 4'hF);
    run(6);
    chk("t3_unr70", underrun, 1'b0);
    run(1);
    chk("t3_unr71", underrun, 1'b1);
    for (int k = 0; k < 8; k++) begin
      run(1);
      chk("t3_col1", coloridx, 4'd0);
    end
    mode = 0;
    step(1, 0);
    chk("t3_unr_clr", underrun, 1'b0);

    // line_start during F2 together with a pixel tick
    pat  = 0;
    row  = 8'h33;
    mode = 2;
    step(1, 0);
    run(5);
    mode = 0;
    step(0, 0);
    step(0, 0);
    chk("t4_f2", bus.SRAM_ADDR, 16'hC033);
    mode = 2;
    row  = 8'h44;
    step(1, 1);
    chk("t4_hcnt", dut.hcnt, 9'd0);
    chk("t4_addr", bus.SRAM_ADDR, 16'h8044);
    chk("t4_valid", dut.fetch_valid, 1'b0);
    mode = 0;
    run(65);
    chk("t4_pix0", coloridx, 4'b1001);

    // reset while pixels are active
    reset = 1'b1;
    step(0, 0);
    chk("t5_cidx", coloridx, 4'd0);
    chk("t5_bdr", borderx, 1'b1);
    chk("t5_addr", bus.SRAM_ADDR, 16'h8000);
    chk("t5_unr", underrun, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 100; k++) begin
      run(1);
      chk("t5_hold", bus.SRAM_ADDR, 16'h8000);
      chk("t5_pix", coloridx, 4'd0);
    end
    step(1, 0);
    chk("t5_ls", bus.SRAM_ADDR, 16'h8044);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
